fpmult_es_pipe: RTL and testbench
=================================

# fpmult_es_pipe

Parametrised, pipelined exponent/sign datapath for the FP multiplier. It computes the biased product exponent and the product sign for any IEEE-style exponent width. It classifies special operands (zero, infinity, NaN) and flags exponent overflow/underflow. A valid/ready handshake with per-stage backpressure lets it sit between operand unpacking and the mantissa normaliser at full throughput.

## Interface
Parameters:
- EXP_W, 8: exponent field width (≥ 4).
- BIAS, 2**(EXP_W-1)-1: exponent bias subtracted once from the sum.
- STAGES, 2: pipeline register stages (1..4); equals latency.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- ea, eb  in  EXP_W  operand biased exponents.
- sa, sb  in  1  operand signs.
- ma_zero, mb_zero  in  1  operand fraction field is all zeros.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- ep  out  EXP_W+2  product exponent, two's complement signed.
- sp  out  1  product sign.
- flags  out  5  [0] zero, [1] inf, [2] nan, [3] ovf, [4] unf.

## Operation
- Per-operand classification: zero if e==0, with denormals flushed. Inf if e==all-ones && m_zero. NaN if e==all-ones && !m_zero.
- nan = either NaN, or (one zero && other inf).
- inf = either inf && !nan.
- zero = either zero && !nan && !inf.
- sp = sa ^ sb in all cases, including specials.
- ep_raw = ea + eb − BIAS, computed in EXP_W+2 signed bits. Operands are zero-extended, so the sum never wraps.
- ovf = no special && ep_raw ≥ 2**EXP_W−1.
- unf = no special && ep_raw ≤ 0.
- At most one of ovf/unf is set. Neither is set when any special flag is set.
- Without saturation, ep = ep_raw always.
- Handshake:
  - A beat transfers on in_valid && in_ready, and on out_valid && out_ready.
  - Stage k holds a valid bit v[k].
  - ready[k] = !v[k] || ready[k+1], with ready[STAGES] = out_ready.
  - in_ready = ready[0], a combinational chain.
  - Bubbles collapse, so no beat is lost, duplicated or reordered.
- out_valid must not depend combinationally on out_ready.
- Stage data registers load only when the stage's ready is high.

## Timing
- Latency: exactly STAGES cycles from the input transfer to out_valid when out_ready is held high.
- Throughput: one beat per cycle.
- Classification and the adder sit in stage 0. Later stages are pure register slices.
- Reset (asynchronous assert, synchronous deassert assumed upstream): all v[k]=0, out_valid=0, ep=0, sp=0, flags=0.
  - in_ready goes to 1 from the first cycle after deassert.
  - Reset mid-stream discards all in-flight beats.
- Full condition: all stages valid and out_ready=0 forces in_ready=0 in the same cycle.
- Simultaneous accept and emit when full is allowed if out_ready=1.
- in_valid=0 inserts a bubble. Outputs are don't-care while out_valid=0, but registers hold their last value.

## Configuration
- FPMULT_ES_SATURATE_EN defined, ep is clamped to the encodable range:
  - ep = all-ones (2**EXP_W−1) on ovf, inf or nan.
  - ep = 0 on unf or zero.
  - Otherwise ep = ep_raw.
  - Upper two ep bits are then always 0.
- FPMULT_ES_SATURATE_EN undefined, ep = ep_raw unconditionally. Flags are identical in both builds.

## Structure
- Package fpmult_es_pkg holds:
  - flag index localparams (FLG_ZERO..FLG_UNF) and the flag width 5;
  - a classify function returning {zero, inf, nan} per operand.
- Sub-module fpmult_es_stage: one valid/ready register slice, parametrised on payload width. It is instantiated STAGES times in a generate loop; stage 0's payload is {ep, sp, flags}.

## Test plan
- Normal product, EXP_W=8, STAGES=2: ea=127, eb=128, sa=0, sb=1 → after 2 cycles ep=128, sp=1, flags=0.
- Overflow: ea=254, eb=254 → ep_raw=381, flags[3]=1; saturate build ep=255, non-saturate ep=10'd381.
- Underflow: ea=1, eb=1 → ep_raw=−125 (10'h383), flags[4]=1; saturate build ep=0.
- Specials:
  - ea=0 × (eb=255, mb_zero=1) → nan=1, saturate ep=255.
  - ea=255 with ma_zero=0 → nan=1.
  - ea=255 with ma_zero=1, eb=100 → inf=1 only.
- Backpressure: stream 10 beats with out_ready low for cycles 3–7 → in_ready low once 2 beats are held; all 10 results emerge in order, no duplicates.
- Reset: assert rst_n=0 with 2 beats in flight → out_valid=0 immediately; after release the first new beat appears STAGES cycles after acceptance.

Source files
------------

// File: rtl/fpmult_es_pkg.sv
// rtl/fpmult_es_pkg.sv - shared flag indices and operand classification for the FP multiplier exponent/sign path
package fpmult_es_pkg;

    localparam int FLG_ZERO = 0;
    localparam int FLG_INF  = 1;
    localparam int FLG_NAN  = 2;
    localparam int FLG_OVF  = 3;
    localparam int FLG_UNF  = 4;
    localparam int FLG_W    = 5;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
    } cls_t;

    // Denormals are flushed: an all-zero exponent counts as zero whatever the fraction.
    function automatic cls_t classify(input logic e_zero, input logic e_ones, input logic m_zero);
        cls_t c;
        c.zero = e_zero;
        c.inf  = e_ones && m_zero;
        c.nan  = e_ones && !m_zero;
        return c;
    endfunction

endpackage

// File: rtl/fpmult_es_pipe_if.sv
// rtl/fpmult_es_pipe_if.sv - operand/result handshake bundle of the exponent/sign pipeline
interface fpmult_es_pipe_if
    import fpmult_es_pkg::*;
#(
    parameter int EXP_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [EXP_W-1:0]   ea;
    logic [EXP_W-1:0]   eb;
    logic               sa;
    logic               sb;
    logic               ma_zero;
    logic               mb_zero;
    logic               out_valid;
    logic               out_ready;
    logic [EXP_W+1:0]   ep;
    logic               sp;
    logic [FLG_W-1:0]   flags;

    modport master (
        output in_valid, ea, eb, sa, sb, ma_zero, mb_zero, out_ready,
        input  in_ready, out_valid, ep, sp, flags
    );

    modport slave (
        input  in_valid, ea, eb, sa, sb, ma_zero, mb_zero, out_ready,
        output in_ready, out_valid, ep, sp, flags
    );

endinterface

// File: rtl/fpmult_es_stage.sv
// rtl/fpmult_es_stage.sv - one valid/ready register slice with a parametrised payload
module fpmult_es_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         ready_next,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         ready
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Data only moves on a real beat so the outputs hold their last value across bubbles.
    always_comb begin
        ready   = !valid_q || ready_next;
        valid_d = valid_q;
        data_d  = data_q;
        if (ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/fpmult_es_pipe.sv
// rtl/fpmult_es_pipe.sv - pipelined product exponent/sign with special-operand flags; FPMULT_ES_SATURATE_EN clamps ep
module fpmult_es_pipe
    import fpmult_es_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int BIAS   = 2**(EXP_W-1)-1,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    fpmult_es_pipe_if.slave bus
);

    localparam int EP_W = EXP_W + 2;
    localparam int PW   = EP_W + 1 + FLG_W;

    cls_t             ca, cb;
    logic             nan, inf, zero, special, ovf, unf;
    logic [EP_W-1:0]  ep_raw;
    logic [EP_W-1:0]  ep_s0;
    logic [FLG_W-1:0] flags_s0;

    always_comb begin
        ca = classify(bus.ea == '0, &bus.ea, bus.ma_zero);
        cb = classify(bus.eb == '0, &bus.eb, bus.mb_zero);

        nan     = ca.nan || cb.nan || (ca.zero && cb.inf) || (ca.inf && cb.zero);
        inf     = (ca.inf || cb.inf) && !nan;
        zero    = (ca.zero || cb.zero) && !nan && !inf;
        special = nan || inf || zero;

        // Two guard bits keep the zero-extended sum from wrapping; the MSB is the sign.
        ep_raw = {2'b00, bus.ea} + {2'b00, bus.eb} - EP_W'(BIAS);
        ovf    = !special && !ep_raw[EP_W-1]
                 && (ep_raw[EP_W-2:0] >= (EP_W-1)'((2**EXP_W) - 1));
        unf    = !special && (ep_raw[EP_W-1] || (ep_raw == '0));

`ifdef FPMULT_ES_SATURATE_EN
        if (ovf || inf || nan) begin
            ep_s0 = EP_W'((2**EXP_W) - 1);
        end else if (unf || zero) begin
            ep_s0 = '0;
        end else begin
            ep_s0 = ep_raw;
        end
`else
        ep_s0 = ep_raw;
`endif

        flags_s0           = '0;
        flags_s0[FLG_ZERO] = zero;
        flags_s0[FLG_INF]  = inf;
        flags_s0[FLG_NAN]  = nan;
        flags_s0[FLG_OVF]  = ovf;
        flags_s0[FLG_UNF]  = unf;
    end

    // Index k is the input side of slice k; index STAGES is the output port.
    logic          vld [0:STAGES];
    logic          rdy [0:STAGES];
    logic [PW-1:0] dat [0:STAGES];

    assign vld[0]      = bus.in_valid;
    assign dat[0]      = {ep_s0, bus.sa ^ bus.sb, flags_s0};
    assign rdy[STAGES] = bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        fpmult_es_stage #(
            .W(PW)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (vld[k]),
            .in_data    (dat[k]),
            .ready_next (rdy[k+1]),
            .valid      (vld[k+1]),
            .data       (dat[k+1]),
            .ready      (rdy[k])
        );
    end

    assign bus.in_ready                = rdy[0];
    assign bus.out_valid               = vld[STAGES];
    assign {bus.ep, bus.sp, bus.flags} = dat[STAGES];

endmodule

// File: tb/tb_fpmult_es_pipe.sv
// tb/tb_fpmult_es_pipe.sv - scoreboard bench for fpmult_es_pipe (EXP_W=8, STAGES=2)
module tb_fpmult_es_pipe;
    import fpmult_es_pkg::*;

    localparam int STAGES = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpmult_es_pipe_if #(.EXP_W(8)) bus ();

    fpmult_es_pipe #(
        .EXP_W  (8),
        .STAGES (STAGES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [7:0] ea, eb;
        logic       sa, sb, maz, mbz;
        logic [9:0] ep_ns, ep_sat;
        logic       sp;
        logic [4:0] fl;
    } vec_t;

    typedef struct {
        logic [9:0] ep;
        logic       sp;
        logic [4:0] fl;
        int         acc;
        bit         lat;
    } exp_t;

    vec_t vt [14];
    exp_t sbq [$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   n_out = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(input logic [7:0] ea, input logic [7:0] eb, input logic sa,
                                 input logic sb, input logic maz, input logic mbz,
                                 input logic [9:0] ep_ns, input logic [9:0] ep_sat,
                                 input logic sp, input logic [4:0] fl);
        vec_t v;
        v.ea = ea; v.eb = eb; v.sa = sa; v.sb = sb; v.maz = maz; v.mbz = mbz;
        v.ep_ns = ep_ns; v.ep_sat = ep_sat; v.sp = sp; v.fl = fl;
        return v;
    endfunction

    function automatic logic [9:0] exp_ep(input vec_t v);
`ifdef FPMULT_ES_SATURATE_EN
        return v.ep_sat;
`else
        return v.ep_ns;
`endif
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat actual_ep=%0h expected=none", bus.ep);
            end else begin
                e = sbq.pop_front();
                n_out++;
                chk("ep", 32'(bus.ep), 32'(e.ep));
                chk("sp", 32'(bus.sp), 32'(e.sp));
                chk("flags", 32'(bus.flags), 32'(e.fl));
                if (e.lat) chk("latency", 32'(cyc - e.acc), 32'(STAGES));
            end
        end
    end

    task automatic send(input int i, input bit lat);
        exp_t e;
        bus.ea      = vt[i].ea;
        bus.eb      = vt[i].eb;
        bus.sa      = vt[i].sa;
        bus.sb      = vt[i].sb;
        bus.ma_zero = vt[i].maz;
        bus.mb_zero = vt[i].mbz;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.ep  = exp_ep(vt[i]);
                e.sp  = vt[i].sp;
                e.fl  = vt[i].fl;
                e.acc = cyc;
                e.lat = lat;
                sbq.push_back(e);
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        tests++;
        fails++;
        $display("FAIL send_timeout vec=%0d actual=no_accept expected=accept", i);
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 100 && sbq.size() != 0; t++) @(posedge clk);
        @(posedge clk);
        #1;
        chk(name, 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        //            ea    eb    sa    sb    maz   mbz   ep_ns    ep_sat   sp    flags
        vt[0]  = mkv(8'd127, 8'd128, 1'b0, 1'b1, 1'b1, 1'b1, 10'h080, 10'h080, 1'b1, 5'h00);
        vt[1]  = mkv(8'd254, 8'd254, 1'b0, 1'b0, 1'b1, 1'b1, 10'h17D, 10'h0FF, 1'b0, 5'h08);
        vt[2]  = mkv(8'd1,   8'd1,   1'b0, 1'b0, 1'b1, 1'b1, 10'h383, 10'h000, 1'b0, 5'h10);
        vt[3]  = mkv(8'd0,   8'd255, 1'b1, 1'b0, 1'b1, 1'b1, 10'h080, 10'h0FF, 1'b1, 5'h04);
        vt[4]  = mkv(8'd255, 8'd10,  1'b0, 1'b0, 1'b0, 1'b1, 10'h08A, 10'h0FF, 1'b0, 5'h04);
        vt[5]  = mkv(8'd255, 8'd100, 1'b0, 1'b1, 1'b1, 1'b1, 10'h0E4, 10'h0FF, 1'b1, 5'h02);
        vt[6]  = mkv(8'd0,   8'd50,  1'b1, 1'b1, 1'b1, 1'b1, 10'h3B3, 10'h000, 1'b0, 5'h01);
        vt[7]  = mkv(8'd127, 8'd254, 1'b0, 1'b0, 1'b1, 1'b1, 10'h0FE, 10'h0FE, 1'b0, 5'h00);
        vt[8]  = mkv(8'd128, 8'd254, 1'b1, 1'b0, 1'b1, 1'b1, 10'h0FF, 10'h0FF, 1'b1, 5'h08);
        vt[9]  = mkv(8'd64,  8'd64,  1'b0, 1'b0, 1'b1, 1'b1, 10'h001, 10'h001, 1'b0, 5'h00);
        vt[10] = mkv(8'd63,  8'd64,  1'b0, 1'b1, 1'b1, 1'b1, 10'h000, 10'h000, 1'b1, 5'h10);
        vt[11] = mkv(8'd255, 8'd255, 1'b1, 1'b1, 1'b1, 1'b1, 10'h17F, 10'h0FF, 1'b0, 5'h02);
        vt[12] = mkv(8'd0,   8'd0,   1'b0, 1'b1, 1'b0, 1'b0, 10'h381, 10'h000, 1'b1, 5'h01);
        vt[13] = mkv(8'd255, 8'd255, 1'b0, 1'b0, 1'b0, 1'b1, 10'h17F, 10'h0FF, 1'b0, 5'h04);

        bus.in_valid = 1'b0;
        bus.ea = '0; bus.eb = '0; bus.sa = 1'b0; bus.sb = 1'b0;
        bus.ma_zero = 1'b1; bus.mb_zero = 1'b1;
        bus.out_ready = 1'b1;

        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ep", 32'(bus.ep), 32'd0);
        chk("rst_sp", 32'(bus.sp), 32'd0);
        chk("rst_flags", 32'(bus.flags), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            send(i, 1'b1);
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        drain("drain_isolated");

        for (int i = 0; i < 14; i++) send(i, 1'b1);
        bus.in_valid = 1'b0;
        drain("drain_back_to_back");

        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 10; i++) send(i, 1'b0);
                bus.in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (4) @(posedge clk);
                @(negedge clk);
                chk("full_in_ready", 32'(bus.in_ready), 32'd0);
                chk("full_out_valid", 32'(bus.out_valid), 32'd1);
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");
        chk("bp_count", 32'(n_out - n0), 32'd10);

        bus.out_ready = 1'b0;
        send(1, 1'b0);
        send(2, 1'b0);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("midrst_ep", 32'(bus.ep), 32'd0);
        chk("midrst_flags", 32'(bus.flags), 32'd0);
        bus.out_ready = 1'b1;
        n0 = n_out;
        send(5, 1'b1);
        bus.in_valid = 1'b0;
        drain("drain_after_reset");
        repeat (4) @(posedge clk);
        #1;
        chk("post_reset_count", 32'(n_out - n0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
